matmul_engine: RTL
==================

# matmul_engine

Parametrised successor to the single-shot matrix multiplier: a memory-mapped engine that reads a 4-word dimension header, then computes C = A×B or C = C + A×B over signed fixed-width operands. It sits as a bus master on the user-area memory port, started by a one-cycle pulse from the control block and reporting done/error back to it. Compared with the previous generation it adds width/depth parameters, an accumulate mode, dimension checking, a req/ack handshake with wait states, and optional saturation.

## Interface
- DATA_W, 32: operand/result word width, two's complement.
- ADDR_W, 32: memory word-address width.
- ACC_W, 72: accumulator width, must be at least 2*DATA_W.
- MAX_DIM, 256: largest legal value of any matrix dimension.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle start pulse, sampled only in IDLE.
- mode_acc  in  1  0: C = A×B; 1: C = C + A×B. Latched with start.
- mem_ack  in  1  transfer completes on a cycle where mem_req && mem_ack.
- mem_rdata  in  DATA_W  read data, valid on the ack cycle of a read.
- mem_req  out  1  request, held until acked.
- mem_we  out  1  1 for write, 0 for read; stable while mem_req is high.
- mem_addr  out  ADDR_W  word address; stable while mem_req is high.
- mem_wdata  out  DATA_W  write data; stable while mem_req is high.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  set with done on a rejected job; cleared by the next accepted start.

## Operation
- Memory layout in words:
  - Header at addresses 0..3: width_a, height_a, width_b, height_b.
  - A at 4, row-major.
  - B at 4 + height_a*width_a.
  - C at B_base + height_b*width_b.
- States: IDLE, HDR, CHECK, LD_C, LD_A, LD_B, MAC, WR, FIN.
- IDLE:
  - start → HDR; latch mode_acc; clear error; clear i, j, k.
  - start is ignored in every other state.
- HDR: four reads at addresses 0, 1, 2, 3. Header words are stored as unsigned.
- CHECK: one cycle with no memory access.
  - Goes to FIN with error=1 and no C writes if any dimension is 0, any dimension is > MAX_DIM, or width_a ≠ height_b.
  - Otherwise goes to LD_C if mode_acc, else to LD_A.
- Loop order: i over height_a, j over width_b, k over width_a (k innermost).
- LD_C: reads C[i][j], sign-extends it to ACC_W and uses it as the accumulator initial value. Without mode_acc the accumulator starts at 0.
- LD_A: reads A[i][k] at A_base + i*width_a + k.
- LD_B: reads B[k][j] at B_base + k*width_b + j.
- MAC:
  - acc += signed(A) × signed(B). The product is 2*DATA_W bits, sign-extended to ACC_W.
  - Accumulator overflow wraps at ACC_W.
- After the last k: WR writes the result to C_base + i*width_b + j. The result is formatted per Configuration.
- Next element: after WR, advance j, then i. Go to LD_C or LD_A, or to FIN after the last element.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Address arithmetic is modulo 2^ADDR_W.

## Timing
- Reset values of all outputs: mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, error 0. State resets to IDLE.
- Asserting reset_n low mid-transfer drops mem_req immediately (asynchronous). The job is lost and no further writes occur.
- Handshake:
  - mem_req rises in the first cycle of each LD_*/WR state.
  - On the ack cycle the engine captures mem_rdata (reads), and in the next cycle either issues the next request or deasserts mem_req.
  - Back-to-back requests are allowed.
  - mem_ack while mem_req=0 is ignored.
  - Each wait cycle (ack low) extends latency by exactly one cycle.
- Zero-wait latency (mem_ack tied 1), counting from the IDLE cycle that samples start to the done pulse:
  - Valid job: 4 + 1 + H*W*(3K + 1 + mode_acc) + 1 cycles, with H = height_a, W = width_b, K = width_a.
  - Rejected job: 4 + 1 + 1 cycles.
- A start pulse coincident with done is ignored. The engine accepts start from the cycle after done.

## Configuration
- MATMUL_SAT_EN defined: on WR, an accumulator outside [-2^(DATA_W-1), 2^(DATA_W-1)-1] is clamped to the nearest bound.
- MATMUL_SAT_EN undefined: WR writes acc[DATA_W-1:0] (wrap).
- MAC behaviour is identical in both builds.

## Test plan
- 2×2 × 2×2, A=[1,2;3,4], B=[5,6;7,8], mode_acc=0, ack tied 1 → C=[19,22;43,50] at addresses 12..15, done at cycle 34, error=0.
- Same job with mode_acc=1 and C preloaded [1,1,1,1] → C=[20,23;44,51], done at cycle 38.
- Header width_a=3, height_b=2 → no writes, done with error=1 at cycle 6. A following valid start clears error.
- 1×1, DATA_W=8, A=100, B=100:
  - With MATMUL_SAT_EN → C=127.
  - Without → C=16 (10000 mod 256). Repeat with A=-100 → saturated result -128.
- Random mem_ack stalls (50%) on the 2×2 job → identical results; mem_addr/mem_we/mem_wdata stable while mem_req is high and unacked.
- reset_n low during the third LD_B → mem_req low in the same cycle, all outputs at reset values. A new start then runs the job to completion correctly.

Source files
------------

// File: rtl/matmul_engine_if.sv
// Memory-port bundle for matmul_engine (engine is master, memory is slave).
//
// Handshake: the master raises req with we/addr/wdata and holds all of them
// stable until the slave answers with ack in the same cycle; a transfer
// completes on every cycle where req && ack, and read data on rdata is valid
// only on that cycle. ack while req is low carries no meaning. The master may
// present the next request in the cycle directly after an ack.
interface matmul_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output we, output addr, output wdata,
                    input  ack, input  rdata);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output ack, output rdata);
endinterface

// File: rtl/matmul_engine.sv
// matmul_engine: memory-mapped matrix multiplier, C = A*B or C = C + A*B.
// Reads a 4-word header (width_a, height_a, width_b, height_b) at address 0,
// A follows at 4 row-major, then B, then C. Signed DATA_W operands are
// accumulated at ACC_W bits (wrapping) with k as the innermost loop.
// Optional build macro MATMUL_SAT_EN: clamp results to the DATA_W signed
// range on write; when undefined the low DATA_W bits are written.
// Assumes DATA_W >= $clog2(MAX_DIM+1) so a legal dimension fits one word.
module matmul_engine #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int ACC_W   = 72,
    parameter int MAX_DIM = 256
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               mode_acc,
    matmul_engine_if.master    mem,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [3:0]         state_dbg
);

    localparam int DIM_W = $clog2(MAX_DIM + 1);
    localparam int CMP_W = (DATA_W > 32) ? DATA_W + 1 : 33;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_HDR   = 4'd1;
    localparam logic [3:0] S_CHECK = 4'd2;
    localparam logic [3:0] S_LD_C  = 4'd3;
    localparam logic [3:0] S_LD_A  = 4'd4;
    localparam logic [3:0] S_LD_B  = 4'd5;
    localparam logic [3:0] S_MAC   = 4'd6;
    localparam logic [3:0] S_WR    = 4'd7;
    localparam logic [3:0] S_FIN   = 4'd8;

    localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(4);

`ifdef MATMUL_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    logic [3:0]        state;
    logic [1:0]        hdr_idx;
    logic [DATA_W-1:0] hdr [4];
    logic              mode_q;
    logic [DIM_W-1:0]  i, j, k;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] a_q, b_q;

    logic [DIM_W-1:0]  wa, ha, wb, hb;
    logic              hdr_bad;
    logic [ADDR_W-1:0] b_base, c_base;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext, acc_sum, c_ext;
    logic              last_k, last_j, last_elem;
    logic [DIM_W-1:0]  nxt_i, nxt_j, el_i, el_j;
    logic [ADDR_W-1:0] el_addr;
    logic [3:0]        el_state;

    // A header word is illegal when zero or larger than MAX_DIM (unsigned).
    function automatic logic dim_bad(input logic [DATA_W-1:0] d);
        return (d == '0) || (CMP_W'(d) > CMP_W'(MAX_DIM));
    endfunction

    // Row-major element address, wrapping at ADDR_W.
    function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [DIM_W-1:0]  row,
                                                    input logic [DIM_W-1:0]  ncols,
                                                    input logic [DIM_W-1:0]  col);
        return base + ADDR_W'(row) * ADDR_W'(ncols) + ADDR_W'(col);
    endfunction

    // Narrow the accumulator to a result word.
    function automatic logic [DATA_W-1:0] fmt(input logic [ACC_W-1:0] a);
`ifdef MATMUL_SAT_EN
        if ($signed(a) > SAT_MAX) return SAT_MAX[DATA_W-1:0];
        if ($signed(a) < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        return a[DATA_W-1:0];
`else
        return a[DATA_W-1:0];
`endif
    endfunction

    assign wa = hdr[0][DIM_W-1:0];
    assign ha = hdr[1][DIM_W-1:0];
    assign wb = hdr[2][DIM_W-1:0];
    assign hb = hdr[3][DIM_W-1:0];

    assign state_dbg = state;

    // Header validation, matrix bases, MAC datapath and loop-advance decode.
    always_comb begin
        hdr_bad  = dim_bad(hdr[0]) || dim_bad(hdr[1]) || dim_bad(hdr[2]) ||
                   dim_bad(hdr[3]) || (hdr[0] != hdr[3]);
        b_base   = A_BASE + ADDR_W'(ha) * ADDR_W'(wa);
        c_base   = b_base + ADDR_W'(hb) * ADDR_W'(wb);

        prod     = $signed(a_q) * $signed(b_q);
        prod_ext = ACC_W'(prod);
        acc_sum  = acc + prod_ext;
        c_ext    = ACC_W'($signed(mem.rdata));

        last_k    = (k == wa - DIM_W'(1));
        last_j    = (j == wb - DIM_W'(1));
        last_elem = last_j && (i == ha - DIM_W'(1));
        nxt_j     = last_j ? '0 : j + DIM_W'(1);
        nxt_i     = last_j ? i + DIM_W'(1) : i;

        // First request of the next output element (from CHECK: element 0,0).
        el_i     = (state == S_CHECK) ? '0 : nxt_i;
        el_j     = (state == S_CHECK) ? '0 : nxt_j;
        el_state = mode_q ? S_LD_C : S_LD_A;
        el_addr  = mode_q ? elem_addr(c_base, el_i, wb, el_j)
                          : elem_addr(A_BASE, el_i, wa, '0);
    end

    // Job sequencer: header fetch, check, per-element load/MAC/write loop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            hdr_idx   <= '0;
            for (int n = 0; n < 4; n++) hdr[n] <= '0;
            mode_q    <= 1'b0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_HDR;
                        mode_q   <= mode_acc;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        i        <= '0;
                        j        <= '0;
                        k        <= '0;
                        hdr_idx  <= '0;
                        mem.req  <= 1'b1;
                        mem.we   <= 1'b0;
                        mem.addr <= '0;
                    end
                end
                S_HDR: begin
                    if (mem.ack) begin
                        hdr[hdr_idx] <= mem.rdata;
                        if (hdr_idx == 2'd3) begin
                            mem.req <= 1'b0;
                            state   <= S_CHECK;
                        end else begin
                            hdr_idx  <= hdr_idx + 2'd1;
                            mem.addr <= mem.addr + ADDR_W'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (hdr_bad) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FIN;
                    end else begin
                        acc      <= '0;
                        state    <= el_state;
                        mem.req  <= 1'b1;
                        mem.we   <= 1'b0;
                        mem.addr <= el_addr;
                    end
                end
                S_LD_C: begin
                    if (mem.ack) begin
                        acc      <= c_ext;
                        state    <= S_LD_A;
                        mem.addr <= elem_addr(A_BASE, i, wa, '0);
                    end
                end
                S_LD_A: begin
                    if (mem.ack) begin
                        a_q      <= mem.rdata;
                        state    <= S_LD_B;
                        mem.addr <= elem_addr(b_base, k, wb, j);
                    end
                end
                S_LD_B: begin
                    if (mem.ack) begin
                        b_q     <= mem.rdata;
                        mem.req <= 1'b0;
                        state   <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc     <= acc_sum;
                    mem.req <= 1'b1;
                    if (last_k) begin
                        k         <= '0;
                        state     <= S_WR;
                        mem.we    <= 1'b1;
                        mem.addr  <= elem_addr(c_base, i, wb, j);
                        mem.wdata <= fmt(acc_sum);
                    end else begin
                        k        <= k + DIM_W'(1);
                        state    <= S_LD_A;
                        mem.addr <= elem_addr(A_BASE, i, wa, k + DIM_W'(1));
                    end
                end
                S_WR: begin
                    if (mem.ack) begin
                        mem.we <= 1'b0;
                        if (last_elem) begin
                            mem.req <= 1'b0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_FIN;
                        end else begin
                            i        <= nxt_i;
                            j        <= nxt_j;
                            acc      <= '0;
                            state    <= el_state;
                            mem.addr <= el_addr;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
